// File: rtl/tnkiii_video_pkg.sv
// rtl/tnkiii_video_pkg.sv - Timing defaults, counter types and window helpers for the TNK III video timing generator
package tnkiii_video_pkg;

  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_H_TOTAL      = 384;
  localparam int DEF_H_ACT_START  = 48;
  localparam int DEF_H_ACT_END    = 336;
  localparam int DEF_H_SYNC_START = 352;
  localparam int DEF_H_SYNC_END   = 384;
  localparam int DEF_V_TOTAL      = 264;
  localparam int DEF_V_ACT_START  = 16;
  localparam int DEF_V_ACT_END    = 232;
  localparam int DEF_V_SYNC_START = 240;
  localparam int DEF_V_SYNC_END   = 248;

  localparam int CNT_W = 9;

  typedef logic [CNT_W-1:0] hv_cnt_t;
  // One spare bit so an end bound can equal a full 512-count total
  typedef logic [CNT_W:0]   hv_bound_t;

  typedef struct packed {
    hv_bound_t h_act_start;
    hv_bound_t h_act_end;
    hv_bound_t h_sync_start;
    hv_bound_t h_sync_end;
    hv_bound_t v_act_start;
    hv_bound_t v_act_end;
    hv_bound_t v_sync_start;
    hv_bound_t v_sync_end;
  } timing_cfg_t;

  // Half-open window [lo, hi); lo > hi means the window wraps through zero
  function automatic logic in_window(hv_cnt_t cnt, hv_bound_t lo, hv_bound_t hi);
    hv_bound_t c;
    c = {1'b0, cnt};
    if (lo <= hi) return (c >= lo) && (c < hi);
    return (c >= lo) || (c < hi);
  endfunction

  function automatic hv_bound_t adj_bound(int base, logic [3:0] adj, int total);
    int s;
    s = base + int'($signed(adj));
    if (s < 0) s = s + total;
    else if (s >= total) s = s - total;
    return hv_bound_t'(s);
  endfunction

endpackage

// File: rtl/tnkiii_pix_cen_div.sv
// rtl/tnkiii_pix_cen_div.sv - System-clock divider producing the ck1 / ck1n pixel strobes
module tnkiii_pix_cen_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic ck1_stb,
  output logic ck1n_stb
);

  localparam int W = $clog2(CLK_DIV);

  logic [W-1:0] div_cnt_q, div_cnt_d;

  always_comb begin
    div_cnt_d = div_cnt_q + W'(1);
    if (div_cnt_q == W'(CLK_DIV - 1)) div_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_cnt_q <= '0;
    else     div_cnt_q <= div_cnt_d;
  end

  // Strobes mark the last divider count of each phase; the top registers them
  assign ck1_stb  = (div_cnt_q == W'(CLK_DIV - 1));
  assign ck1n_stb = (div_cnt_q == W'(CLK_DIV / 2 - 1));

endmodule

// File: rtl/tnkiii_video_timing_gen.sv
// rtl/tnkiii_video_timing_gen.sv - Pixel enables, H/V counters and registered sync/blank decodes; TNKIII_TIMING_ADJ_EN adds H_ADJ/V_ADJ sync trim
module tnkiii_video_timing_gen
  import tnkiii_video_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_TOTAL      = DEF_H_TOTAL,
  parameter int H_ACT_START  = DEF_H_ACT_START,
  parameter int H_ACT_END    = DEF_H_ACT_END,
  parameter int H_SYNC_START = DEF_H_SYNC_START,
  parameter int H_SYNC_END   = DEF_H_SYNC_END,
  parameter int V_TOTAL      = DEF_V_TOTAL,
  parameter int V_ACT_START  = DEF_V_ACT_START,
  parameter int V_ACT_END    = DEF_V_ACT_END,
  parameter int V_SYNC_START = DEF_V_SYNC_START,
  parameter int V_SYNC_END   = DEF_V_SYNC_END
) (
  input  logic       clk,
  input  logic       rst,
`ifdef TNKIII_TIMING_ADJ_EN
  input  logic [3:0] H_ADJ,
  input  logic [3:0] V_ADJ,
`endif
  output logic       CK1,
  output logic       CK1n,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       H1,
  output logic       HD8,
  output logic       DISP,
  output logic       HBLANK,
  output logic       VBLANK,
  output logic       HSYNC_n,
  output logic       VSYNC_n,
  output logic       VBL_IRQ
);

  if (H_TOTAL > 512 || V_TOTAL > 512) begin : g_bad_total
    $fatal(1, "tnkiii_video_timing_gen: H_TOTAL and V_TOTAL must not exceed 512");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $fatal(1, "tnkiii_video_timing_gen: CLK_DIV must be even and at least 2");
  end

  localparam timing_cfg_t CFG = '{
    h_act_start:  hv_bound_t'(H_ACT_START),
    h_act_end:    hv_bound_t'(H_ACT_END),
    h_sync_start: hv_bound_t'(H_SYNC_START),
    h_sync_end:   hv_bound_t'(H_SYNC_END),
    v_act_start:  hv_bound_t'(V_ACT_START),
    v_act_end:    hv_bound_t'(V_ACT_END),
    v_sync_start: hv_bound_t'(V_SYNC_START),
    v_sync_end:   hv_bound_t'(V_SYNC_END)
  };

  logic      ck1_stb, ck1n_stb;
  logic      ck1_q, ck1_d, ck1n_q, ck1n_d;
  hv_cnt_t   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic      disp_q, disp_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic      hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic      vbl_irq_q, vbl_irq_d;
  hv_bound_t h_sync_lo, h_sync_hi, v_sync_lo, v_sync_hi;

  tnkiii_pix_cen_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .ck1_stb  (ck1_stb),
    .ck1n_stb (ck1n_stb)
  );

  always_comb begin
    ck1_d     = ck1_stb;
    ck1n_d    = ck1n_stb;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    vbl_irq_d = 1'b0;
    if (ck1_stb) begin
      if (hcnt_q == hv_cnt_t'(H_TOTAL - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == hv_cnt_t'(V_TOTAL - 1)) ? '0 : vcnt_q + 9'd1;
      end else begin
        hcnt_d = hcnt_q + 9'd1;
      end
      vbl_irq_d = (hcnt_d == '0) && ({1'b0, vcnt_d} == CFG.v_act_end);
    end
  end

`ifdef TNKIII_TIMING_ADJ_EN
  logic [3:0] h_adj_q, h_adj_d, v_adj_q, v_adj_d;

  // Trim is taken only as the frame wraps so a frame never sees two sync positions
  always_comb begin
    h_adj_d = h_adj_q;
    v_adj_d = v_adj_q;
    if (ck1_stb && hcnt_d == '0 && vcnt_d == '0) begin
      h_adj_d = H_ADJ;
      v_adj_d = V_ADJ;
    end
    h_sync_lo = adj_bound(H_SYNC_START, h_adj_d, H_TOTAL);
    h_sync_hi = adj_bound(H_SYNC_END,   h_adj_d, H_TOTAL);
    v_sync_lo = adj_bound(V_SYNC_START, v_adj_d, V_TOTAL);
    v_sync_hi = adj_bound(V_SYNC_END,   v_adj_d, V_TOTAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_adj_q <= '0;
      v_adj_q <= '0;
    end else begin
      h_adj_q <= h_adj_d;
      v_adj_q <= v_adj_d;
    end
  end
`else
  assign h_sync_lo = CFG.h_sync_start;
  assign h_sync_hi = CFG.h_sync_end;
  assign v_sync_lo = CFG.v_sync_start;
  assign v_sync_hi = CFG.v_sync_end;
`endif

  // Decode the next counter values so flags land in the same cycle as HCNT/VCNT
  always_comb begin
    hblank_d  = !in_window(hcnt_d, CFG.h_act_start, CFG.h_act_end);
    vblank_d  = !in_window(vcnt_d, CFG.v_act_start, CFG.v_act_end);
    disp_d    = !hblank_d && !vblank_d;
    hsync_n_d = !in_window(hcnt_d, h_sync_lo, h_sync_hi);
    vsync_n_d = !in_window(vcnt_d, v_sync_lo, v_sync_hi);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ck1_q     <= 1'b0;
      ck1n_q    <= 1'b0;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      disp_q    <= 1'b0;
      hblank_q  <= 1'b1;
      vblank_q  <= 1'b1;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      vbl_irq_q <= 1'b0;
    end else begin
      ck1_q     <= ck1_d;
      ck1n_q    <= ck1n_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      disp_q    <= disp_d;
      hblank_q  <= hblank_d;
      vblank_q  <= vblank_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      vbl_irq_q <= vbl_irq_d;
    end
  end

  assign CK1     = ck1_q;
  assign CK1n    = ck1n_q;
  assign HCNT    = hcnt_q;
  assign VCNT    = vcnt_q;
  assign H1      = hcnt_q[0];
  assign HD8     = hcnt_q[3];
  assign DISP    = disp_q;
  assign HBLANK  = hblank_q;
  assign VBLANK  = vblank_q;
  assign HSYNC_n = hsync_n_q;
  assign VSYNC_n = vsync_n_q;
  assign VBL_IRQ = vbl_irq_q;

endmodule

// File: doc/tnkiii_video_timing_gen.md
Name: tnkiii_video_timing_gen

Overview:
Master video sequencer for the TNK III / Athena final-video datapath. It divides the system clock into the pixel clock-enables CK1/CK1n and runs the horizontal and vertical counters. From those counters it derives H1, HD8, DISP, sync, blank and vblank-IRQ. These signals drive the line-buffer/side/background mux, the colour-index latches and the RGB output latches of the final-video stage.

Parameters:
CLK_DIV, 4, clk cycles per pixel; must be even and ≥2 (24 MHz → 6 MHz)
H_TOTAL, 384, pixels per line
H_ACT_START, 48, first visible pixel
H_ACT_END, 336, first non-visible pixel after the active region (288 visible)
H_SYNC_START, 352, first hsync pixel
H_SYNC_END, 384, hsync ends at line wrap
V_TOTAL, 264, lines per frame
V_ACT_START, 16, first visible line
V_ACT_END, 232, first non-visible line after the active region (216 visible)
V_SYNC_START, 240, first vsync line
V_SYNC_END, 248, first line after vsync

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
CK1  out  1  pixel clock-enable pulse, one clk wide
CK1n  out  1  half-phase pixel clock-enable pulse, one clk wide
HCNT  out  9  horizontal pixel counter
VCNT  out  9  vertical line counter
H1  out  1  HCNT[0] level
HD8  out  1  HCNT[3] level
DISP  out  1  high inside the active window
HBLANK  out  1  high outside the horizontal active region
VBLANK  out  1  high outside the vertical active region
HSYNC_n  out  1  active-low horizontal sync
VSYNC_n  out  1  active-low vertical sync
VBL_IRQ  out  1  one-clk pulse at the start of vblank

Behaviour:
- Reset values: div_cnt=0, HCNT=0, VCNT=0, CK1=0, CK1n=0, H1=0, HD8=0, DISP=0, HBLANK=1, VBLANK=1, HSYNC_n=1, VSYNC_n=1, VBL_IRQ=0. Reset applies on the clk edge where rst=1, including mid-frame; counting restarts from (0,0).
- Divider: div_cnt counts 0..CLK_DIV-1 and then wraps.
  - CK1 is registered high for the cycle after div_cnt==CLK_DIV-1.
  - CK1n is registered high for the cycle after div_cnt==CLK_DIV/2-1.
  - CK1 and CK1n are never high together.
- Counters advance only on clk cycles where the internal ck1 strobe fires. CK1, HCNT and VCNT are registered on the same edge, so downstream logic sees the new HCNT in the same cycle as CK1.
- HCNT wraps H_TOTAL-1 → 0. VCNT increments on that same wrap.
- VCNT wraps V_TOTAL-1 → 0. Simultaneous H and V wrap gives (0,0) in one step.
- Derived outputs are registered decodes of the post-increment counter values, so they change in the same cycle as HCNT/VCNT (zero extra latency relative to the counters):
  - HBLANK = !(H_ACT_START ≤ HCNT < H_ACT_END)
  - VBLANK = !(V_ACT_START ≤ VCNT < V_ACT_END)
  - DISP = !HBLANK & !VBLANK
  - HSYNC_n = !(H_SYNC_START ≤ HCNT < H_SYNC_END)
  - VSYNC_n = !(V_SYNC_START ≤ VCNT < V_SYNC_END)
- VBL_IRQ: a single clk pulse on the CK1 cycle where VCNT becomes V_ACT_END and HCNT becomes 0. There is no re-pulse while VCNT stays constant.
- Counter arithmetic is 9-bit unsigned. Parameter checks in elaboration: H_TOTAL ≤ 512 and V_TOTAL ≤ 512; violation is a fatal error.

Optional Feature:
Macro TNKIII_TIMING_ADJ_EN.
- Defined: adds inputs H_ADJ[3:0] and V_ADJ[3:0] (signed, two's complement). The sync windows use H_SYNC_START+H_ADJ / H_SYNC_END+H_ADJ and V_SYNC_START+V_ADJ / V_SYNC_END+V_ADJ, computed modulo the respective total. Adjust values are sampled only at frame wrap (HCNT=0, VCNT=0) so sync is never torn mid-frame.
- Undefined: the ports are absent and sync windows are the fixed parameters.

Decomposition:
- Package tnkiii_video_pkg holds: the default timing localparams, the 9-bit counter typedef hv_cnt_t, and a timing_cfg_t struct of the start/end pairs.
- One sub-module is natural: tnkiii_pix_cen_div (divider generating ck1/ck1n strobes, parameter CLK_DIV).

Test Plan:
1. Reset deasserted at cycle 0, CLK_DIV=4 → CK1n high at cycles 2, 6, 10…; CK1 high at cycles 4, 8, 12…; the two never overlap.
2. Run one line → HCNT goes 383→0 with VCNT +1 on the same CK1; DISP first high at HCNT=48 and low at 336 (on a visible line); HSYNC_n low for HCNT 352..383.
3. Run a full frame → VCNT 263→0 together with HCNT 383→0; VBL_IRQ exactly one pulse at (HCNT=0, VCNT=232); VSYNC_n low for lines 240..247; 101,376 CK1 pulses per frame.
4. Assert rst for one cycle at HCNT=200, VCNT=100 → next cycle all outputs at reset values, and counting restarts from (0,0).
5. Check H1 toggles every CK1 and HD8 toggles every 8 CK1, both matching HCNT bits.
6. With TNKIII_TIMING_ADJ_EN and H_ADJ=-2 applied mid-frame → the current frame is unchanged; the next frame's HSYNC_n is low for HCNT 350..381.
